// File: rtl/hazard_pipe_ctrl_pkg.sv
// Shared definitions for the hazard / pipeline-control tracker and its neighbours
// (forwarding unit, control unit): register-zero index, hazard codes, control-bit layout.
package hazard_pipe_ctrl_pkg;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        HZ_NONE = 2'd0,
        HZ_LU   = 2'd1,
        HZ_BRA  = 2'd2,
        HZ_BRL  = 2'd3
    } hazard_e;

    // Bit positions inside ctrl_t, shared with the forwarding and control units.
    localparam int CTRL_W         = 3;
    localparam int CTRL_MEM_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_REG_WRITE = 2;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

endpackage

// File: rtl/hazard_pipe_ctrl_hazard_detect.sv
// Combinational load-use / branch-in-ID hazard detection; register 0 never matches.
module hazard_detect
    import hazard_pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_beq,
    input  logic                  id_bne,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  idex_reg_write,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_mem_read,
    output logic                  br,
    output logic                  stall,
    output logic [1:0]            hazard_code
);

    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    logic lu;
    logic bra;
    logic brl;

    always_comb begin
        br  = id_valid && (id_beq || id_bne);
        lu  = idex_mem_read && (idex_rd != ZERO) &&
              ((idex_rd == id_rs) || (id_uses_rt && (idex_rd == id_rt)));
        // A branch resolves in ID, so it waits on any in-flight producer in EX
        // and additionally on a load still in MEM.
        bra = br && idex_reg_write && (idex_rd != ZERO) &&
              ((idex_rd == id_rs) || (idex_rd == id_rt));
        brl = br && exmem_mem_read && (exmem_rd != ZERO) &&
              ((exmem_rd == id_rs) || (exmem_rd == id_rt));
        stall = id_valid && (lu || bra || brl);

        hazard_code = HZ_NONE;
        if (stall) begin
            if (lu) begin
                hazard_code = HZ_LU;
            end else if (bra) begin
                hazard_code = HZ_BRA;
            end else begin
                hazard_code = HZ_BRL;
            end
        end
    end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline-register tracker, stall FSM and error flag feeding the forwarding unit.
// Optional HAZARD_PERF_COUNT_EN adds saturating stall/flush performance counters.
module hazard_pipe_ctrl
    import hazard_pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_STALL  = 2,
    parameter int COUNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_beq,
    input  logic                  id_bne,
    input  logic                  id_take_branch,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic [REG_ADDR_W-1:0] idex_rs,
    output logic [REG_ADDR_W-1:0] idex_rt,
    output logic [REG_ADDR_W-1:0] idex_rd,
    output logic [REG_ADDR_W-1:0] exmem_rd,
    output logic [REG_ADDR_W-1:0] memwb_rd,
    output logic                  idex_reg_write,
    output logic                  idex_mem_read,
    output logic                  idex_mem_write,
    output logic                  exmem_reg_write,
    output logic                  exmem_mem_read,
    output logic                  exmem_mem_write,
    output logic                  memwb_reg_write,
    output logic                  memwb_mem_read,
    output logic [1:0]            hazard_code,
    output logic                  err_stall,
    output logic [COUNT_W-1:0]    stall_count,
    output logic [COUNT_W-1:0]    flush_count
);

    localparam int                SCNT_W   = $clog2(MAX_STALL + 2);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(MAX_STALL);

    logic [REG_ADDR_W-1:0] idex_rs_q, idex_rs_d;
    logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
    logic [REG_ADDR_W-1:0] idex_rd_q, idex_rd_d;
    ctrl_t                 idex_ctrl_q, idex_ctrl_d;
    logic [REG_ADDR_W-1:0] exmem_rd_q, exmem_rd_d;
    ctrl_t                 exmem_ctrl_q, exmem_ctrl_d;
    logic [REG_ADDR_W-1:0] memwb_rd_q, memwb_rd_d;
    logic                  memwb_reg_write_q, memwb_reg_write_d;
    logic                  memwb_mem_read_q, memwb_mem_read_d;
    hazard_e               state_q, state_d;
    logic [SCNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                  err_stall_q, err_stall_d;

    logic                  br;
    logic                  stall;
    logic [1:0]            hz_code;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_beq         (id_beq),
        .id_bne         (id_bne),
        .idex_rd        (idex_rd_q),
        .idex_reg_write (idex_ctrl_q.reg_write),
        .idex_mem_read  (idex_ctrl_q.mem_read),
        .exmem_rd       (exmem_rd_q),
        .exmem_mem_read (exmem_ctrl_q.mem_read),
        .br             (br),
        .stall          (stall),
        .hazard_code    (hz_code)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        idex_rs_d   = '0;
        idex_rt_d   = '0;
        idex_rd_d   = '0;
        idex_ctrl_d = '0;
        if (id_valid && !stall) begin
            idex_rs_d   = id_rs;
            idex_rt_d   = id_rt;
            idex_rd_d   = id_rd;
            idex_ctrl_d = '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write};
        end

        exmem_rd_d        = idex_rd_q;
        exmem_ctrl_d      = idex_ctrl_q;
        memwb_rd_d        = exmem_rd_q;
        memwb_reg_write_d = exmem_ctrl_q.reg_write;
        memwb_mem_read_d  = exmem_ctrl_q.mem_read;

        state_d     = stall ? hazard_e'(hz_code) : HZ_NONE;
        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == SCNT_MAX) ? stall_cnt_q : stall_cnt_q + SCNT_W'(1);
        end
        err_stall_d = err_stall_q || (stall && (stall_cnt_q == SCNT_MAX));
    end

    // NOTE: the pipeline registers are reset (they are not a memory) because the
    // hazard terms read them combinationally and must see bubbles after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_rs_q         <= '0;
            idex_rt_q         <= '0;
            idex_rd_q         <= '0;
            idex_ctrl_q       <= '0;
            exmem_rd_q        <= '0;
            exmem_ctrl_q      <= '0;
            memwb_rd_q        <= '0;
            memwb_reg_write_q <= 1'b0;
            memwb_mem_read_q  <= 1'b0;
            state_q           <= HZ_NONE;
            stall_cnt_q       <= '0;
            err_stall_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples the pre-edge value of the one before it.
            idex_rs_q         <= idex_rs_d;
            idex_rt_q         <= idex_rt_d;
            idex_rd_q         <= idex_rd_d;
            idex_ctrl_q       <= idex_ctrl_d;
            exmem_rd_q        <= exmem_rd_d;
            exmem_ctrl_q      <= exmem_ctrl_d;
            memwb_rd_q        <= memwb_rd_d;
            memwb_reg_write_q <= memwb_reg_write_d;
            memwb_mem_read_q  <= memwb_mem_read_d;
            state_q           <= state_d;
            stall_cnt_q       <= stall_cnt_d;
            err_stall_q       <= err_stall_d;
        end
    end

    assign pc_write        = !stall;
    assign ifid_write      = !stall;
    assign ifid_flush      = id_take_branch && br && !stall;
    assign idex_rs         = idex_rs_q;
    assign idex_rt         = idex_rt_q;
    assign idex_rd         = idex_rd_q;
    assign idex_reg_write  = idex_ctrl_q.reg_write;
    assign idex_mem_read   = idex_ctrl_q.mem_read;
    assign idex_mem_write  = idex_ctrl_q.mem_write;
    assign exmem_rd        = exmem_rd_q;
    assign exmem_reg_write = exmem_ctrl_q.reg_write;
    assign exmem_mem_read  = exmem_ctrl_q.mem_read;
    assign exmem_mem_write = exmem_ctrl_q.mem_write;
    assign memwb_rd        = memwb_rd_q;
    assign memwb_reg_write = memwb_reg_write_q;
    assign memwb_mem_read  = memwb_mem_read_q;
    assign hazard_code     = state_q;
    assign err_stall       = err_stall_q;

`ifdef HAZARD_PERF_COUNT_EN
    logic [COUNT_W-1:0] stall_count_q, stall_count_d;
    logic [COUNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + COUNT_W'(1);
        end
        if (ifid_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: table of per-cycle ID instructions with expected stall/flush
// and pipeline contents, a scoreboard of post-edge state, plus reset-mid-stall and error-flag runs.
module tb_hazard_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
    logic       id_beq, id_bne, id_take_branch;

    logic       pc_write, ifid_write, ifid_flush;
    logic [4:0] idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
    logic       idex_reg_write, idex_mem_read, idex_mem_write;
    logic       exmem_reg_write, exmem_mem_read, exmem_mem_write;
    logic       memwb_reg_write, memwb_mem_read;
    logic [1:0] hazard_code;
    logic       err_stall;
    logic [31:0] stall_count, flush_count;

    // Second instance: one legal stall only, 2-bit counters.
    logic       pc_write_b, ifid_write_b, ifid_flush_b;
    logic [4:0] idex_rs_b, idex_rt_b, idex_rd_b, exmem_rd_b, memwb_rd_b;
    logic       idex_reg_write_b, idex_mem_read_b, idex_mem_write_b;
    logic       exmem_reg_write_b, exmem_mem_read_b, exmem_mem_write_b;
    logic       memwb_reg_write_b, memwb_mem_read_b;
    logic [1:0] hazard_code_b;
    logic       err_stall_b;
    logic [1:0] stall_count_b, flush_count_b;

    always #5 clk = ~clk;

    hazard_pipe_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_beq(id_beq), .id_bne(id_bne), .id_take_branch(id_take_branch),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
        .memwb_reg_write(memwb_reg_write), .memwb_mem_read(memwb_mem_read),
        .hazard_code(hazard_code), .err_stall(err_stall), .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_pipe_ctrl #(.MAX_STALL(1), .COUNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_beq(id_beq), .id_bne(id_bne), .id_take_branch(id_take_branch),
        .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
        .idex_rs(idex_rs_b), .idex_rt(idex_rt_b), .idex_rd(idex_rd_b), .exmem_rd(exmem_rd_b), .memwb_rd(memwb_rd_b),
        .idex_reg_write(idex_reg_write_b), .idex_mem_read(idex_mem_read_b), .idex_mem_write(idex_mem_write_b),
        .exmem_reg_write(exmem_reg_write_b), .exmem_mem_read(exmem_mem_read_b), .exmem_mem_write(exmem_mem_write_b),
        .memwb_reg_write(memwb_reg_write_b), .memwb_mem_read(memwb_mem_read_b),
        .hazard_code(hazard_code_b), .err_stall(err_stall_b), .stall_count(stall_count_b), .flush_count(flush_count_b)
    );

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs, rt, rd;
        logic       ut, rw, mr, mw, beq, bne, take;
        logic       x_stall, x_flush;
        logic [1:0] x_code;
        logic [4:0] x_idex_rd;
        logic       x_idex_rw, x_idex_mr;
        logic [4:0] x_exmem_rd, x_memwb_rd;
    } vec_t;

    typedef struct packed {
        logic [1:0] code;
        logic [4:0] idex_rs, idex_rt, idex_rd;
        logic       idex_rw, idex_mr, idex_mw;
        logic [4:0] exmem_rd;
        logic       exmem_rw, exmem_mr, exmem_mw;
        logic [4:0] memwb_rd;
        logic       memwb_rw, memwb_mr;
    } exp_t;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t tbl [23];
    exp_t sb_q [$];
    exp_t sh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t ins(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic ut,
                                 logic rw, logic mr, logic mw, logic beq, logic bne, logic take);
        vec_t r;
        r.name = ""; r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.ut = ut;
        r.rw = rw; r.mr = mr; r.mw = mw; r.beq = beq; r.bne = bne; r.take = take;
        r.x_stall = 1'b0; r.x_flush = 1'b0; r.x_code = 2'd0; r.x_idex_rd = '0;
        r.x_idex_rw = 1'b0; r.x_idex_mr = 1'b0; r.x_exmem_rd = '0; r.x_memwb_rd = '0;
        return r;
    endfunction

    function automatic vec_t i_lw(logic [4:0] rd, logic [4:0] base);
        return ins(1, base, 0, rd, 0, 1, 1, 0, 0, 0, 0);
    endfunction
    function automatic vec_t i_alu(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        return ins(1, rs, rt, rd, 1, 1, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t i_sw(logic [4:0] rs, logic [4:0] rt);
        return ins(1, rs, rt, 0, 1, 0, 0, 1, 0, 0, 0);
    endfunction
    function automatic vec_t i_br(logic is_bne, logic [4:0] rs, logic [4:0] rt, logic take);
        return ins(1, rs, rt, 0, 1, 0, 0, 0, !is_bne, is_bne, take);
    endfunction
    function automatic vec_t i_nop();
        return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t i_bad_br(logic is_bne, logic [4:0] rs, logic [4:0] rt);
        return ins(0, rs, rt, 0, 1, 0, 0, 0, !is_bne, is_bne, 1);
    endfunction

    function automatic vec_t xp(vec_t i, string name, logic st, logic fl, logic [1:0] code,
                                logic [4:0] idrd, logic idrw, logic idmr, logic [4:0] exrd, logic [4:0] wbrd);
        vec_t r = i;
        r.name = name; r.x_stall = st; r.x_flush = fl; r.x_code = code; r.x_idex_rd = idrd;
        r.x_idex_rw = idrw; r.x_idex_mr = idmr; r.x_exmem_rd = exrd; r.x_memwb_rd = wbrd;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.v; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_uses_rt = v.ut;
        id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw;
        id_beq = v.beq; id_bne = v.bne; id_take_branch = v.take;
    endtask

    task automatic check_pipe_clear(input string tag);
        check({tag, ".pc_write"}, pc_write, 1);
        check({tag, ".ifid_write"}, ifid_write, 1);
        check({tag, ".hazard_code"}, hazard_code, 0);
        check({tag, ".idex_rd"}, idex_rd, 0);
        check({tag, ".idex_reg_write"}, idex_reg_write, 0);
        check({tag, ".exmem_rd"}, exmem_rd, 0);
        check({tag, ".exmem_mem_read"}, exmem_mem_read, 0);
        check({tag, ".memwb_rd"}, memwb_rd, 0);
        check({tag, ".memwb_reg_write"}, memwb_reg_write, 0);
        check({tag, ".err_stall"}, err_stall, 0);
        check({tag, ".err_stall_b"}, err_stall_b, 0);
    endtask

    task automatic step(input vec_t v);
        exp_t e, g;
        @(negedge clk);
        drive(v);
        #1;
        check({v.name, ".pc_write"}, pc_write, !v.x_stall);
        check({v.name, ".ifid_write"}, ifid_write, !v.x_stall);
        check({v.name, ".ifid_flush"}, ifid_flush, v.x_flush);
        e = '0;
        e.code     = v.x_code;
        e.idex_rs  = (v.v && !v.x_stall) ? v.rs : 5'd0;
        e.idex_rt  = (v.v && !v.x_stall) ? v.rt : 5'd0;
        e.idex_rd  = v.x_idex_rd;
        e.idex_rw  = v.x_idex_rw;
        e.idex_mr  = v.x_idex_mr;
        e.idex_mw  = v.v && !v.x_stall && v.mw;
        e.exmem_rd = v.x_exmem_rd;
        e.exmem_rw = sh.idex_rw;
        e.exmem_mr = sh.idex_mr;
        e.exmem_mw = sh.idex_mw;
        e.memwb_rd = v.x_memwb_rd;
        e.memwb_rw = sh.exmem_rw;
        e.memwb_mr = sh.exmem_mr;
        sh = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check({v.name, ".hazard_code"}, hazard_code, g.code);
        check({v.name, ".idex_rs"}, idex_rs, g.idex_rs);
        check({v.name, ".idex_rt"}, idex_rt, g.idex_rt);
        check({v.name, ".idex_rd"}, idex_rd, g.idex_rd);
        check({v.name, ".idex_reg_write"}, idex_reg_write, g.idex_rw);
        check({v.name, ".idex_mem_read"}, idex_mem_read, g.idex_mr);
        check({v.name, ".idex_mem_write"}, idex_mem_write, g.idex_mw);
        check({v.name, ".exmem_rd"}, exmem_rd, g.exmem_rd);
        check({v.name, ".exmem_reg_write"}, exmem_reg_write, g.exmem_rw);
        check({v.name, ".exmem_mem_read"}, exmem_mem_read, g.exmem_mr);
        check({v.name, ".exmem_mem_write"}, exmem_mem_write, g.exmem_mw);
        check({v.name, ".memwb_rd"}, memwb_rd, g.memwb_rd);
        check({v.name, ".memwb_reg_write"}, memwb_reg_write, g.memwb_rw);
        check({v.name, ".memwb_mem_read"}, memwb_mem_read, g.memwb_mr);
        check({v.name, ".err_stall"}, err_stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                            name         st fl code idrd rw mr exrd wbrd
        tbl[0]  = xp(i_lw(8, 4),       "t1_lw",     0, 0, 0,   8,  1, 1, 0,   0);
        tbl[1]  = xp(i_alu(9, 8, 10),  "t1_add",    1, 0, 1,   0,  0, 0, 8,   0);
        tbl[2]  = xp(i_alu(9, 8, 10),  "t1_add_r",  0, 0, 0,   9,  1, 0, 0,   8);
        tbl[3]  = xp(i_nop(),          "t1_nop0",   0, 0, 0,   0,  0, 0, 9,   0);
        tbl[4]  = xp(i_nop(),          "t1_nop1",   0, 0, 0,   0,  0, 0, 0,   9);
        tbl[5]  = xp(i_nop(),          "t1_nop2",   0, 0, 0,   0,  0, 0, 0,   0);
        tbl[6]  = xp(i_alu(8, 1, 2),   "t2_add",    0, 0, 0,   8,  1, 0, 0,   0);
        tbl[7]  = xp(i_br(0, 8, 9, 1), "t2_beq",    1, 0, 2,   0,  0, 0, 8,   0);
        tbl[8]  = xp(i_br(0, 8, 9, 1), "t2_beq_r",  0, 1, 0,   0,  0, 0, 0,   8);
        tbl[9]  = xp(i_nop(),          "t2_nop0",   0, 0, 0,   0,  0, 0, 0,   0);
        tbl[10] = xp(i_nop(),          "t2_nop1",   0, 0, 0,   0,  0, 0, 0,   0);
        tbl[11] = xp(i_lw(8, 4),       "t3_lw",     0, 0, 0,   8,  1, 1, 0,   0);
        tbl[12] = xp(i_br(0, 9, 8, 0), "t3_beq_s1", 1, 0, 1,   0,  0, 0, 8,   0);
        tbl[13] = xp(i_br(0, 9, 8, 0), "t3_beq_s2", 1, 0, 3,   0,  0, 0, 0,   8);
        tbl[14] = xp(i_br(0, 9, 8, 0), "t3_beq_r",  0, 0, 0,   0,  0, 0, 0,   0);
        tbl[15] = xp(i_nop(),          "t3_nop",    0, 0, 0,   0,  0, 0, 0,   0);
        tbl[16] = xp(i_lw(0, 4),       "t4_lw0",    0, 0, 0,   0,  1, 1, 0,   0);
        tbl[17] = xp(i_alu(9, 0, 0),   "t4_add0",   0, 0, 0,   9,  1, 0, 0,   0);
        tbl[18] = xp(i_sw(6, 5),       "t4_sw",     0, 0, 0,   0,  0, 0, 9,   0);
        tbl[19] = xp(i_lw(8, 4),       "t4_lw8",    0, 0, 0,   8,  1, 1, 0,   9);
        tbl[20] = xp(i_bad_br(0, 8, 8),"t4_inv_beq",0, 0, 0,   0,  0, 0, 8,   0);
        tbl[21] = xp(i_bad_br(1, 8, 8),"t4_inv_bne",0, 0, 0,   0,  0, 0, 0,   8);
        tbl[22] = xp(i_nop(),          "t4_nop",    0, 0, 0,   0,  0, 0, 0,   0);

        sh = '0;
        drive(i_nop());
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_pipe_clear("reset");
        check("reset.ifid_flush", ifid_flush, 0);
        check("reset.stall_count", stall_count, 0);
        check("reset.flush_count", flush_count, 0);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i]);
        end

        check("t3.err_stall_b", err_stall_b, 1);
`ifdef HAZARD_PERF_COUNT_EN
        check("t6.stall_count", stall_count, 4);
        check("t6.flush_count", flush_count, 1);
        check("t6.stall_count_sat", stall_count_b, 3);
        check("t6.flush_count_b", flush_count_b, 1);
`else
        check("cnt_off.stall_count", stall_count, 0);
        check("cnt_off.flush_count", flush_count, 0);
        check("cnt_off.stall_count_b", stall_count_b, 0);
`endif

        // Reset asserted in the second stall cycle of load-then-branch.
        step(tbl[11]);
        step(tbl[12]);
        @(negedge clk);
        drive(tbl[13]);
        #1;
        check("t5.pre_pc_write", pc_write, 0);
        check("t5.pre_hazard_code", hazard_code, 1);
        reset = 1'b1;
        #1;
        check_pipe_clear("t5.async");
        check("t5.async.ifid_flush", ifid_flush, 0);
        check("t5.async.stall_count", stall_count, 0);
        @(posedge clk);
        #1;
        check_pipe_clear("t5.held");
        @(negedge clk);
        drive(i_nop());
        reset = 1'b0;
        sh = '0;
        for (int i = 0; i < 6; i++) begin
            step(tbl[i]);
        end
`ifdef HAZARD_PERF_COUNT_EN
        check("t5.resume.stall_count", stall_count, 1);
        check("t5.resume.flush_count", flush_count, 0);
`endif
        check("t5.resume.err_stall_b", err_stall_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
